// File: rtl/rtcl_p3s7_hs_recv_ctrl_pkg.sv
// Shared definitions for the PYTHON300 HS receive controller.
//   state_t     : controller state encoding, also exported on the state port
//   HDR_BIT_FS  : lane-0 header byte bit flagging a frame-start packet
//   HDR_BIT_FE  : lane-0 header byte bit flagging a frame-end packet
package rtcl_p3s7_hs_recv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RESET   = 2'd1,
      ST_WAIT_FS = 2'd2,
      ST_FRAME   = 2'd3
   } state_t;

   localparam int unsigned HDR_BIT_FS = 0;
   localparam int unsigned HDR_BIT_FE = 1;

endpackage

// File: rtl/rtcl_p3s7_hs_recv_watchdog.sv
// Header-stream stall watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : clock enable; counter holds while low
//   clear      : zero the counter (takes priority over counting)
//   run        : count one per enabled cycle
//   threshold  : firing threshold; 0 disables firing
//   fire       : high in the enabled cycle in which the count reaches threshold
module rtcl_p3s7_hs_recv_watchdog #(
   parameter int unsigned CNT_BITS = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  logic                run,
   input  logic [CNT_BITS-1:0] threshold,
   output logic                fire
);

   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [CNT_BITS:0]   cnt_next;

   // fire does not look at clear; the caller resolves header-vs-timeout
   // priority so no combinational path runs from its state logic back here.
   always_comb begin
      cnt_next = {1'b0, cnt_q} + 1'b1;
      cnt_d    = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
      fire = en && run && (threshold != '0) && (cnt_next >= {1'b0, threshold});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rtcl_p3s7_hs_recv_ctrl.sv
// Frame-level sequencer for the PYTHON300 HS D-PHY receive path.
//   aresetn, aclk, aclken       : async active-low reset, clock, clock enable
//   ctl_enable / ctl_update     : run level / shadow-to-active load request
//   ctl_timeout                 : watchdog threshold in cycles, 0 disables
//   shadow_* / param_*          : pending and active image geometry
//   header_data / header_valid  : packet header strobe from the receiver
//   recv_reset                  : receiver reset request (active high)
//   update_ack                  : one-cycle pulse when params are loaded
//   busy / state                : state != IDLE / state encoding
//   frame_count, line_count, size_error_count, timeout_count : statistics
module rtcl_p3s7_hs_recv_ctrl
   import rtcl_p3s7_hs_recv_ctrl_pkg::*;
#(
   parameter int unsigned X_BITS       = 10,
   parameter int unsigned Y_BITS       = 10,
   parameter int unsigned DPHY_LANES   = 2,
   parameter int unsigned TIMEOUT_BITS = 24,
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic                    aresetn,
   input  logic                    aclk,
   input  logic                    aclken,
   input  logic                    ctl_enable,
   input  logic                    ctl_update,
   input  logic [TIMEOUT_BITS-1:0] ctl_timeout,
   input  logic [X_BITS-1:0]       shadow_black_width,
   input  logic [X_BITS-1:0]       shadow_image_width,
   input  logic [Y_BITS-1:0]       shadow_black_height,
   input  logic [Y_BITS-1:0]       shadow_image_height,
   output logic [X_BITS-1:0]       param_black_width,
   output logic [X_BITS-1:0]       param_image_width,
   output logic [Y_BITS-1:0]       param_black_height,
   output logic [Y_BITS-1:0]       param_image_height,
   input  logic [DPHY_LANES*8-1:0] header_data,
   input  logic                    header_valid,
   output logic                    recv_reset,
   output logic                    update_ack,
   output logic                    busy,
   output logic [1:0]              state,
   output logic [31:0]             frame_count,
   output logic [Y_BITS-1:0]       line_count,
   output logic [15:0]             size_error_count,
   output logic [15:0]             timeout_count
);

   localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

   state_t              state_q, state_d;
   logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
   logic                pending_q, pending_d;
   logic                recv_reset_q, recv_reset_d;
   logic                busy_q, busy_d;
   logic                update_ack_q, update_ack_d;
   logic [X_BITS-1:0]   act_bw_q, act_iw_q;
   logic [Y_BITS-1:0]   act_bh_q, act_ih_q;
   logic [31:0]         frame_q, frame_d;
   logic [Y_BITS-1:0]   line_q, line_d;
   logic [15:0]         size_err_q, size_err_d;
   logic [15:0]         tmo_q, tmo_d;

   logic [7:0]          hdr_byte;
   logic                hdr_fs, hdr_fe;
   logic                fs_accept, apply;
   logic [Y_BITS:0]     exp_lines;
   logic                wd_clear, wd_run, wd_fire;
   logic                unused_hdr;

   assign unused_hdr = ^header_data[DPHY_LANES*8-1:2];

   // Both type bits set decodes as FE.
   always_comb begin
      hdr_byte = header_data[7:0];
      hdr_fe   = hdr_byte[HDR_BIT_FE];
      hdr_fs   = hdr_byte[HDR_BIT_FS] & ~hdr_fe;
   end

   assign exp_lines = {1'b0, act_bh_q} + {1'b0, act_ih_q};

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = '0;
      frame_d    = frame_q;
      line_d     = line_q;
      size_err_d = size_err_q;
      tmo_d      = tmo_q;
      fs_accept  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ctl_enable) state_d = ST_RESET;
         end
         ST_RESET: begin
            if (!ctl_enable) begin
               state_d = ST_IDLE;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
               if (rst_cnt_q == RC_LAST) state_d = ST_WAIT_FS;
            end
         end
         ST_WAIT_FS: begin
            if (!ctl_enable) begin
               state_d = ST_IDLE;
            end else if (header_valid) begin
               if (hdr_fs) begin
                  fs_accept = 1'b1;
                  line_d    = '0;
                  state_d   = ST_FRAME;
               end
            end else if (wd_fire) begin
               if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
               state_d = ST_RESET;
            end
         end
         ST_FRAME: begin
            // Enable drop only takes effect at FE or timeout here.
            if (header_valid) begin
               if (hdr_fs) begin
                  fs_accept = 1'b1;
                  line_d    = '0;
               end else if (hdr_fe) begin
                  frame_d = frame_q + 1'b1;
                  if (({1'b0, line_q} != exp_lines) && (size_err_q != '1))
                     size_err_d = size_err_q + 1'b1;
                  state_d = ctl_enable ? ST_WAIT_FS : ST_IDLE;
               end else if (line_q != '1) begin
                  line_d = line_q + 1'b1;
               end
            end else if (wd_fire) begin
               if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
               state_d = ctl_enable ? ST_RESET : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A request arriving together with an applying event is consumed at once.
      apply = (pending_q | ctl_update) &
              ((state_q == ST_IDLE) | (state_q == ST_RESET) | fs_accept);
      pending_d    = (pending_q | ctl_update) & ~apply;
      update_ack_d = apply;
      recv_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
      busy_d       = (state_d != ST_IDLE);
   end

   assign wd_run   = (state_q == ST_WAIT_FS) || (state_q == ST_FRAME);
   assign wd_clear = header_valid || (state_d != state_q);

   rtcl_p3s7_hs_recv_watchdog #(
      .CNT_BITS (TIMEOUT_BITS)
   ) u_watchdog (
      .clk       (aclk),
      .rst_n     (aresetn),
      .en        (aclken),
      .clear     (wd_clear),
      .run       (wd_run),
      .threshold (ctl_timeout),
      .fire      (wd_fire)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         rst_cnt_q    <= '0;
         pending_q    <= 1'b0;
         recv_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         update_ack_q <= 1'b0;
         act_bw_q     <= '0;
         act_iw_q     <= '0;
         act_bh_q     <= '0;
         act_ih_q     <= '0;
         frame_q      <= '0;
         line_q       <= '0;
         size_err_q   <= '0;
         tmo_q        <= '0;
      end else if (aclken) begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         pending_q    <= pending_d;
         recv_reset_q <= recv_reset_d;
         busy_q       <= busy_d;
         update_ack_q <= update_ack_d;
         frame_q      <= frame_d;
         line_q       <= line_d;
         size_err_q   <= size_err_d;
         tmo_q        <= tmo_d;
         if (apply) begin
            act_bw_q <= shadow_black_width;
            act_iw_q <= shadow_image_width;
            act_bh_q <= shadow_black_height;
            act_ih_q <= shadow_image_height;
         end
      end
   end

   assign param_black_width  = act_bw_q;
   assign param_image_width  = act_iw_q;
   assign param_black_height = act_bh_q;
   assign param_image_height = act_ih_q;
   assign recv_reset         = recv_reset_q;
   assign update_ack         = update_ack_q;
   assign busy               = busy_q;
   assign state              = state_q;
   assign frame_count        = frame_q;
   assign line_count         = line_q;
   assign size_error_count   = size_err_q;
   assign timeout_count      = tmo_q;

endmodule

// File: tb/tb_rtcl_p3s7_hs_recv_ctrl.sv
module tb_rtcl_p3s7_hs_recv_ctrl;

   logic        aresetn = 1'b0;
   logic        aclk = 1'b0;
   logic        aclken = 1'b1;
   logic        ctl_enable = 1'b0;
   logic        ctl_update = 1'b0;
   logic [23:0] ctl_timeout = '0;
   logic [9:0]  shadow_black_width = '0;
   logic [9:0]  shadow_image_width = '0;
   logic [9:0]  shadow_black_height = '0;
   logic [9:0]  shadow_image_height = '0;
   logic [9:0]  param_black_width, param_image_width;
   logic [9:0]  param_black_height, param_image_height;
   logic [15:0] header_data = '0;
   logic        header_valid = 1'b0;
   logic        recv_reset, update_ack, busy;
   logic [1:0]  state;
   logic [31:0] frame_count;
   logic [9:0]  line_count;
   logic [15:0] size_error_count, timeout_count;

   int unsigned tests = 0;
   int unsigned failed = 0;
   int unsigned n;

   rtcl_p3s7_hs_recv_ctrl #(
      .X_BITS       (10),
      .Y_BITS       (10),
      .DPHY_LANES   (2),
      .TIMEOUT_BITS (24),
      .RESET_CYCLES (16)
   ) dut (
      .aresetn             (aresetn),
      .aclk                (aclk),
      .aclken              (aclken),
      .ctl_enable          (ctl_enable),
      .ctl_update          (ctl_update),
      .ctl_timeout         (ctl_timeout),
      .shadow_black_width  (shadow_black_width),
      .shadow_image_width  (shadow_image_width),
      .shadow_black_height (shadow_black_height),
      .shadow_image_height (shadow_image_height),
      .param_black_width   (param_black_width),
      .param_image_width   (param_image_width),
      .param_black_height  (param_black_height),
      .param_image_height  (param_image_height),
      .header_data         (header_data),
      .header_valid        (header_valid),
      .recv_reset          (recv_reset),
      .update_ack          (update_ack),
      .busy                (busy),
      .state               (state),
      .frame_count         (frame_count),
      .line_count          (line_count),
      .size_error_count    (size_error_count),
      .timeout_count       (timeout_count)
   );

   always #5 aclk = ~aclk;

   task automatic step(input int unsigned cycles);
      repeat (cycles) @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hdr(input logic [7:0] b, input int unsigned cycles);
      header_data  = {8'h00, b};
      header_valid = 1'b1;
      step(cycles);
      header_valid = 1'b0;
      header_data  = '0;
   endtask

   initial begin
      // Reset values
      step(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_recv_reset", 32'(recv_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_update_ack", 32'(update_ack), 32'd0);
      chk("rst_frame_count", frame_count, 32'd0);
      chk("rst_param_ih", 32'(param_image_height), 32'd0);
      aresetn = 1'b1;
      step(1);

      // Load geometry while IDLE: applied on the next edge
      shadow_black_width  = 10'd4;
      shadow_image_width  = 10'd640;
      shadow_black_height = 10'd0;
      shadow_image_height = 10'd480;
      ctl_update = 1'b1;
      step(1);
      ctl_update = 1'b0;
      chk("idle_update_ack", 32'(update_ack), 32'd1);
      chk("idle_param_ih", 32'(param_image_height), 32'd480);
      chk("idle_param_iw", 32'(param_image_width), 32'd640);
      step(1);
      chk("idle_update_ack_drop", 32'(update_ack), 32'd0);

      // Enable: recv_reset falls RESET_CYCLES+1 cycles later
      ctl_enable = 1'b1;
      n = 0;
      do begin
         step(1);
         n++;
      end while (recv_reset && n < 100);
      chk("enable_latency", n, 32'd17);
      chk("enable_state", 32'(state), 32'd2);
      chk("enable_busy", 32'(busy), 32'd1);

      // Good frame: 480 lines against 0+480
      hdr(8'h01, 1);
      chk("fs_state", 32'(state), 32'd3);
      chk("fs_line_count", 32'(line_count), 32'd0);
      hdr(8'h00, 480);
      chk("lines_480", 32'(line_count), 32'd480);
      hdr(8'h02, 1);
      chk("f1_frame_count", frame_count, 32'd1);
      chk("f1_size_err", 32'(size_error_count), 32'd0);
      chk("f1_state", 32'(state), 32'd2);

      // Short frame (479 lines), FE coded with both type bits set
      hdr(8'h01, 1);
      hdr(8'h00, 479);
      hdr(8'h03, 1);
      chk("f2_frame_count", frame_count, 32'd2);
      chk("f2_size_err", 32'(size_error_count), 32'd1);

      // Mid-frame update held until next FS
      hdr(8'h01, 1);
      hdr(8'h00, 10);
      shadow_image_height = 10'd240;
      ctl_update = 1'b1;
      step(1);
      ctl_update = 1'b0;
      step(1);
      chk("mid_no_ack", 32'(update_ack), 32'd0);
      chk("mid_param_held", 32'(param_image_height), 32'd480);
      hdr(8'h00, 470);
      hdr(8'h02, 1);
      chk("f3_size_err", 32'(size_error_count), 32'd1);
      chk("f3_param_held", 32'(param_image_height), 32'd480);
      hdr(8'h01, 1);
      chk("fs_update_ack", 32'(update_ack), 32'd1);
      chk("fs_param_ih", 32'(param_image_height), 32'd240);
      step(1);
      chk("fs_update_ack_drop", 32'(update_ack), 32'd0);

      // FS inside FRAME restarts the line count without counting a frame
      hdr(8'h00, 5);
      hdr(8'h01, 1);
      chk("restart_line_count", 32'(line_count), 32'd0);
      chk("restart_state", 32'(state), 32'd3);
      hdr(8'h00, 240);
      hdr(8'h02, 1);
      chk("f4_frame_count", frame_count, 32'd4);
      chk("f4_size_err", 32'(size_error_count), 32'd1);

      // Watchdog: header on the 100th cycle beats the timeout
      ctl_timeout = 24'd100;
      step(99);
      hdr(8'h00, 1);
      chk("wd_hdr_no_timeout", 32'(timeout_count), 32'd0);
      chk("wd_hdr_state", 32'(state), 32'd2);
      step(99);
      chk("wd_before_fire", 32'(state), 32'd2);
      step(1);
      chk("wd_fire_count", 32'(timeout_count), 32'd1);
      chk("wd_fire_state", 32'(state), 32'd1);
      ctl_timeout = '0;
      n = 0;
      while (recv_reset && n < 100) begin
         step(1);
         n++;
      end
      chk("wd_reset_len", n, 32'd16);
      chk("wd_back_wait_fs", 32'(state), 32'd2);

      // Clock enable low: headers ignored, everything holds
      aclken = 1'b0;
      hdr(8'h01, 3);
      chk("clken_hold_state", 32'(state), 32'd2);
      aclken = 1'b1;
      step(1);

      // Enable dropped in FRAME: stays until FE, which is counted
      hdr(8'h01, 1);
      hdr(8'h00, 240);
      ctl_enable = 1'b0;
      step(3);
      chk("drop_stays_frame", 32'(state), 32'd3);
      hdr(8'h02, 1);
      chk("drop_idle", 32'(state), 32'd0);
      chk("drop_recv_reset", 32'(recv_reset), 32'd1);
      chk("drop_frame_count", frame_count, 32'd5);
      chk("drop_busy", 32'(busy), 32'd0);

      // Async reset mid-frame
      ctl_enable = 1'b1;
      step(17);
      hdr(8'h01, 1);
      hdr(8'h00, 10);
      chk("pre_areset_lines", 32'(line_count), 32'd10);
      #2;
      aresetn = 1'b0;
      #1;
      chk("areset_state", 32'(state), 32'd0);
      chk("areset_line_count", 32'(line_count), 32'd0);
      chk("areset_frame_count", frame_count, 32'd0);
      chk("areset_timeout", 32'(timeout_count), 32'd0);
      chk("areset_param_ih", 32'(param_image_height), 32'd0);
      chk("areset_recv_reset", 32'(recv_reset), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
